// File: rtl/regfile_param.sv
// Parameterised two-read/one-write register file with per-entry valid bits and a flush sweep.
// Define REGFILE_BYPASS_EN to forward accepted write data to a same-address read on the same edge.
module regfile_param #(
    parameter int DATA_W  = 4,
    parameter int ADDR_W  = 3,
    parameter int ZERO_R0 = 0
) (
    input  logic              Clock,
    input  logic              CLRN,
    input  logic              WR,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] LD_DATA,
    input  logic              RE_P,
    input  logic              RE_Q,
    input  logic [ADDR_W-1:0] RP,
    input  logic [ADDR_W-1:0] RQ,
    output logic [DATA_W-1:0] DATAP,
    output logic [DATA_W-1:0] DATAQ,
    output logic              VALIDP,
    output logic              VALIDQ,
    input  logic              FLUSH,
    output logic              BUSY,
    output logic              dbg_state_o
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  vld_q;
    logic [DATA_W-1:0] dp_q, dp_d, dq_q, dq_d;
    logic              vp_q, vp_d, vq_q, vq_d;
    logic              wr_acc;

    // Writes are locked out for the whole sweep; entry 0 is read-only when hardwired to zero.
    assign wr_acc = WR && (state_q == IDLE) && !((ZERO_R0 != 0) && (WA == '0));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (FLUSH) begin
                    state_d = SWEEP;
                    cnt_d   = '0;
                end
            end
            SWEEP: begin
                cnt_d = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        dp_d = dp_q;
        vp_d = vp_q;
        if (RE_P) begin
            dp_d = mem_q[RP];
            vp_d = vld_q[RP];
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && (WA == RP)) begin
                dp_d = LD_DATA;
                vp_d = 1'b1;
            end
`endif
            if ((ZERO_R0 != 0) && (RP == '0)) begin
                dp_d = '0;
                vp_d = 1'b1;
            end
        end
    end

    always_comb begin
        dq_d = dq_q;
        vq_d = vq_q;
        if (RE_Q) begin
            dq_d = mem_q[RQ];
            vq_d = vld_q[RQ];
`ifdef REGFILE_BYPASS_EN
            if (wr_acc && (WA == RQ)) begin
                dq_d = LD_DATA;
                vq_d = 1'b1;
            end
`endif
            if ((ZERO_R0 != 0) && (RQ == '0)) begin
                dq_d = '0;
                vq_d = 1'b1;
            end
        end
    end

    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dp_q    <= '0;
            vp_q    <= 1'b0;
            dq_q    <= '0;
            vq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dp_q    <= dp_d;
            vp_q    <= vp_d;
            dq_q    <= dq_d;
            vq_q    <= vq_d;
        end
    end

    // Sweep clear and port write never coincide because writes need IDLE.
    always_ff @(posedge Clock or negedge CLRN) begin
        if (!CLRN) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            vld_q <= '0;
        end else if (state_q == SWEEP) begin
            mem_q[cnt_q] <= '0;
            vld_q[cnt_q] <= 1'b0;
        end else if (wr_acc) begin
            mem_q[WA] <= LD_DATA;
            vld_q[WA] <= 1'b1;
        end
    end

    assign DATAP       = dp_q;
    assign VALIDP      = vp_q;
    assign DATAQ       = dq_q;
    assign VALIDQ      = vq_q;
    assign BUSY        = (state_q == SWEEP);
    assign dbg_state_o = state_q;

endmodule
